// File: rtl/mast_i2c_pkg.sv
// mast_i2c_pkg: shared widths, defaults and counter-width helper for the master receive path
package mast_i2c_pkg;
    localparam int I2C_BYTE_W        = 8;
    localparam int MAST_RX_DEPTH_DEF = 4;
    localparam int BIT_ORDER_MSB     = 1;
    localparam int BIT_ORDER_LSB     = 0;
    function automatic int clog2_safe(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/mast_sipo_rx_buffer_if.sv
// mast_sipo_rx_buffer_if: receive-buffer bus; slave = buffer side (takes serial/control, drives FIFO read port and status), master = controller/consumer side
interface mast_sipo_rx_buffer_if import mast_i2c_pkg::*; #(
    parameter int DATA_W = I2C_BYTE_W,
    parameter int DEPTH  = MAST_RX_DEPTH_DEF
);
    logic                             master_serial_in;
    logic                             master_rec_data_shift;
    logic                             master_rx_start;
    logic                             master_rx_ready;
    logic                             master_overrun_clr;
    logic [DATA_W-1:0]                master_data_out;
    logic                             master_rx_valid;
    logic [clog2_safe(DEPTH+1)-1:0]   master_rx_count;
    logic [clog2_safe(DATA_W)-1:0]    master_bit_cnt;
    logic                             master_byte_done;
    logic                             master_rx_overrun;
    modport slave (
        input  master_serial_in, master_rec_data_shift, master_rx_start, master_rx_ready, master_overrun_clr,
        output master_data_out, master_rx_valid, master_rx_count, master_bit_cnt, master_byte_done, master_rx_overrun
    );
    modport master (
        output master_serial_in, master_rec_data_shift, master_rx_start, master_rx_ready, master_overrun_clr,
        input  master_data_out, master_rx_valid, master_rx_count, master_bit_cnt, master_byte_done, master_rx_overrun
    );
endinterface

// File: rtl/mast_rx_fifo.sv
// mast_rx_fifo: first-word-fall-through FIFO; clk/rst_n, push+wdata in, pop in, rdata (0 when empty), count, full, empty out
module mast_rx_fifo import mast_i2c_pkg::*; #(
    parameter int DATA_W = I2C_BYTE_W,
    parameter int DEPTH  = MAST_RX_DEPTH_DEF,
    localparam int CW    = clog2_safe(DEPTH+1),
    localparam int PW    = clog2_safe(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              empty
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic              do_push, do_pop;
    assign empty   = count == '0;
    assign full    = count == CW'(DEPTH);
    assign do_pop  = pop && !empty;
    // a full FIFO still accepts a push when the head leaves on the same edge
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(do_push);
            rd_ptr <= rd_ptr + PW'(do_pop);
            count  <= count + CW'(do_push) - CW'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/mast_sipo_rx_buffer.sv
// mast_sipo_rx_buffer: serial-to-word deserialiser with bit counter, word-done strobe, FWFT word FIFO and sticky overrun; master_scl_sixt clock, master_rst_n async reset, everything else on bus
module mast_sipo_rx_buffer import mast_i2c_pkg::*; #(
    parameter int DATA_W    = I2C_BYTE_W,
    parameter int DEPTH     = MAST_RX_DEPTH_DEF,
    parameter int MSB_FIRST = BIT_ORDER_MSB,
    localparam int BW       = clog2_safe(DATA_W),
    localparam int CW       = clog2_safe(DEPTH+1)
) (
    input  logic                  master_scl_sixt,
    input  logic                  master_rst_n,
    mast_sipo_rx_buffer_if.slave  bus
);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W-1);
    logic [DATA_W-1:0] sr, base, shifted;
    logic [BW-1:0]     bit_cnt;
    logic              last, full, empty, overrun;
    logic [CW-1:0]     count;
    always_comb begin
        base    = bus.master_rx_start ? '0 : sr;
        shifted = (MSB_FIRST != 0) ? {base[DATA_W-2:0], bus.master_serial_in}
                                   : {bus.master_serial_in, base[DATA_W-1:1]};
        // a restart on the final-bit cycle cancels the word
        last    = bus.master_rec_data_shift && !bus.master_rx_start && (bit_cnt == LAST_BIT);
    end
    always_ff @(posedge master_scl_sixt or negedge master_rst_n) begin
        if (!master_rst_n) begin
            sr      <= '0;
            bit_cnt <= '0;
            overrun <= 1'b0;
        end else begin
            sr      <= bus.master_rec_data_shift ? shifted : base;
            bit_cnt <= bus.master_rec_data_shift ? (bus.master_rx_start ? BW'(1) : last ? '0 : bit_cnt + BW'(1))
                     : bus.master_rx_start ? '0 : bit_cnt;
            overrun <= (last && full && !(bus.master_rx_ready && !empty)) ? 1'b1
                     : bus.master_overrun_clr ? 1'b0 : overrun;
        end
    end
    mast_rx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (master_scl_sixt),
        .rst_n (master_rst_n),
        .push  (last),
        .wdata (shifted),
        .pop   (bus.master_rx_ready),
        .rdata (bus.master_data_out),
        .count (count),
        .full  (full),
        .empty (empty)
    );
    assign bus.master_rx_valid   = !empty;
    assign bus.master_rx_count   = count;
    assign bus.master_bit_cnt    = bit_cnt;
    assign bus.master_byte_done  = last;
    assign bus.master_rx_overrun = overrun;
endmodule

// File: tb/tb_mast_sipo_rx_buffer.sv
// tb_mast_sipo_rx_buffer: drives an MSB-first and an LSB-first buffer in lockstep and scoreboards their FIFO output
module tb_mast_sipo_rx_buffer;
    import mast_i2c_pkg::*;
    logic clk = 1'b0, rst_n = 1'b0;
    logic serial_in = 1'b0, shift = 1'b0, rx_start = 1'b0, ready = 1'b0, ovr_clr = 1'b0;
    int checks = 0, passes = 0;
    logic [7:0] q_m[$], q_l[$];
    logic exp_ovr = 1'b0;
    always #5 clk = ~clk;
    mast_sipo_rx_buffer_if #(.DATA_W(8), .DEPTH(4)) if_m ();
    mast_sipo_rx_buffer_if #(.DATA_W(8), .DEPTH(4)) if_l ();
    assign if_m.master_serial_in      = serial_in;
    assign if_m.master_rec_data_shift = shift;
    assign if_m.master_rx_start       = rx_start;
    assign if_m.master_rx_ready       = ready;
    assign if_m.master_overrun_clr    = ovr_clr;
    assign if_l.master_serial_in      = serial_in;
    assign if_l.master_rec_data_shift = shift;
    assign if_l.master_rx_start       = rx_start;
    assign if_l.master_rx_ready       = ready;
    assign if_l.master_overrun_clr    = ovr_clr;
    mast_sipo_rx_buffer #(.DATA_W(8), .DEPTH(4), .MSB_FIRST(BIT_ORDER_MSB)) u_msb (
        .master_scl_sixt(clk), .master_rst_n(rst_n), .bus(if_m.slave));
    mast_sipo_rx_buffer #(.DATA_W(8), .DEPTH(4), .MSB_FIRST(BIT_ORDER_LSB)) u_lsb (
        .master_scl_sixt(clk), .master_rst_n(rst_n), .bus(if_l.slave));

    function automatic logic [7:0] rev8(input logic [7:0] w);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = w[7-i];
        return r;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic st, output logic bd_m, output logic bd_l);
        serial_in = b;
        shift     = 1'b1;
        rx_start  = st;
        #1;
        bd_m = if_m.master_byte_done;
        bd_l = if_l.master_byte_done;
        @(posedge clk);
        #1;
        shift    = 1'b0;
        rx_start = 1'b0;
    endtask

    task automatic check_state(input string tag);
        logic [7:0] em, el;
        em = (q_m.size() > 0) ? q_m[0] : 8'h00;
        el = (q_l.size() > 0) ? q_l[0] : 8'h00;
        checks++; if (if_m.master_data_out !== em) $display("FAIL %s msb data_out: got %h want %h", tag, if_m.master_data_out, em); else passes++;
        checks++; if (if_l.master_data_out !== el) $display("FAIL %s lsb data_out: got %h want %h", tag, if_l.master_data_out, el); else passes++;
        checks++; if (if_m.master_rx_count !== 3'(q_m.size())) $display("FAIL %s count: got %0d want %0d", tag, if_m.master_rx_count, q_m.size()); else passes++;
        checks++; if (if_m.master_rx_valid !== (q_m.size() > 0)) $display("FAIL %s valid: got %b want %b", tag, if_m.master_rx_valid, q_m.size() > 0); else passes++;
        checks++; if (if_m.master_rx_overrun !== exp_ovr) $display("FAIL %s overrun: got %b want %b", tag, if_m.master_rx_overrun, exp_ovr); else passes++;
        checks++; if (if_l.master_rx_overrun !== exp_ovr) $display("FAIL %s lsb overrun: got %b want %b", tag, if_l.master_rx_overrun, exp_ovr); else passes++;
    endtask

    // bits go out w[7] first; pop_last raises ready only on the final-bit cycle
    task automatic send_word(input logic [7:0] w, input int gap_max, input logic pop_last, input logic start_last);
        logic bm, bl, exp_bd;
        logic [2:0] bc;
        for (int i = 7; i >= 0; i--) begin
            if (i == 0 && pop_last) begin
                ready = 1'b1;
                #1;
                checks++; if (if_m.master_data_out !== q_m[0]) $display("FAIL pop_last msb head: got %h want %h", if_m.master_data_out, q_m[0]); else passes++;
                checks++; if (if_l.master_data_out !== q_l[0]) $display("FAIL pop_last lsb head: got %h want %h", if_l.master_data_out, q_l[0]); else passes++;
                void'(q_m.pop_front());
                void'(q_l.pop_front());
            end
            send_bit(w[i], (i == 0) && start_last, bm, bl);
            ready  = 1'b0;
            exp_bd = (i == 0) && !start_last;
            checks++; if (bm !== exp_bd) $display("FAIL byte_done msb bit%0d: got %b want %b", i, bm, exp_bd); else passes++;
            checks++; if (bl !== exp_bd) $display("FAIL byte_done lsb bit%0d: got %b want %b", i, bl, exp_bd); else passes++;
            if (gap_max > 0 && i > 0) begin
                repeat ($urandom_range(gap_max, 1)) cyc();
                bc = 3'(8 - i);
                checks++; if (if_m.master_bit_cnt !== bc) $display("FAIL gap bit_cnt: got %0d want %0d", if_m.master_bit_cnt, bc); else passes++;
            end
        end
        if (!start_last) begin
            if (q_m.size() < 4) begin
                q_m.push_back(w);
                q_l.push_back(rev8(w));
            end else exp_ovr = 1'b1;
        end
        check_state("word");
    endtask

    task automatic drain();
        int n = 0;
        ready = 1'b1;
        while (q_m.size() > 0 && n < 8) begin
            #1;
            checks++; if (if_m.master_data_out !== q_m[0]) $display("FAIL drain msb: got %h want %h", if_m.master_data_out, q_m[0]); else passes++;
            checks++; if (if_l.master_data_out !== q_l[0]) $display("FAIL drain lsb: got %h want %h", if_l.master_data_out, q_l[0]); else passes++;
            void'(q_m.pop_front());
            void'(q_l.pop_front());
            cyc();
            n++;
        end
        ready = 1'b0;
        check_state("drained");
    endtask

    task automatic test_reset();
        repeat (2) cyc();
        check_state("reset");
        checks++; if (if_m.master_bit_cnt !== 3'd0 || if_m.master_byte_done !== 1'b0) $display("FAIL reset bit_cnt/byte_done: got %0d/%b want 0/0", if_m.master_bit_cnt, if_m.master_byte_done); else passes++;
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_basic();
        send_word(8'hA5, 0, 1'b0, 1'b0);
        drain();
    endtask

    task automatic test_gaps();
        send_word(8'hA5, 3, 1'b0, 1'b0);
        drain();
    endtask

    task automatic test_bit_order();
        send_word(8'h12, 0, 1'b0, 1'b0);
        checks++; if (if_l.master_data_out !== 8'h48) $display("FAIL lsb order: got %h want 48", if_l.master_data_out); else passes++;
        drain();
    endtask

    task automatic test_overrun();
        for (int i = 1; i <= 5; i++) send_word(8'(i), 0, 1'b0, 1'b0);
        send_word(8'h06, 0, 1'b1, 1'b0);
        drain();
        cyc();
        checks++; if (if_m.master_rx_overrun !== 1'b1) $display("FAIL overrun sticky: got %b want 1", if_m.master_rx_overrun); else passes++;
        ovr_clr = 1'b1;
        cyc();
        ovr_clr = 1'b0;
        exp_ovr = 1'b0;
        check_state("overrun_clr");
    endtask

    task automatic test_rx_start();
        logic bm, bl;
        send_bit(1'b1, 1'b0, bm, bl);
        send_bit(1'b0, 1'b0, bm, bl);
        send_bit(1'b1, 1'b0, bm, bl);
        rx_start = 1'b1;
        cyc();
        rx_start = 1'b0;
        checks++; if (if_m.master_bit_cnt !== 3'd0) $display("FAIL rx_start clear: got %0d want 0", if_m.master_bit_cnt); else passes++;
        send_word(8'hC3, 0, 1'b0, 1'b0);
        drain();
        send_word(8'h99, 0, 1'b0, 1'b1);
        checks++; if (if_m.master_bit_cnt !== 3'd1) $display("FAIL rx_start last bit_cnt: got %0d want 1", if_m.master_bit_cnt); else passes++;
        rx_start = 1'b1;
        cyc();
        rx_start = 1'b0;
    endtask

    task automatic test_async_reset();
        logic bm, bl;
        send_word(8'h11, 0, 1'b0, 1'b0);
        send_word(8'h22, 0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, bm, bl);
        send_bit(1'b1, 1'b0, bm, bl);
        send_bit(1'b0, 1'b0, bm, bl);
        #2;
        rst_n = 1'b0;
        #1;
        q_m.delete();
        q_l.delete();
        exp_ovr = 1'b0;
        check_state("async_reset");
        checks++; if (if_m.master_bit_cnt !== 3'd0) $display("FAIL async_reset bit_cnt: got %0d want 0", if_m.master_bit_cnt); else passes++;
        cyc();
        rst_n = 1'b1;
        cyc();
        send_word(8'h5A, 0, 1'b0, 1'b0);
        drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_bit_order();
        test_overrun();
        test_rx_start();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/mast_sipo_rx_buffer.md
Name: mast_sipo_rx_buffer

Overview:
- Parametrised successor to the master receive SIPO.
- Deserialises slave data sampled on master_scl_sixt into DATA_W-bit words, with bit order selectable by MSB_FIRST.
- Counts bits internally, pulses a word-complete strobe to the master FSM for ACK/NACK timing, and queues completed words in a DEPTH-entry first-word-fall-through FIFO with a valid/ready read port and a sticky overrun flag.

Parameters:
- DATA_W, 8: word width in bits; must be ≥ 2.
- DEPTH, 4: number of FIFO entries; power of 2, ≥ 2.
- MSB_FIRST, 1: 1 = first received bit lands in the MSB (I2C order); 0 = first received bit lands in the LSB.

Ports:
- master_scl_sixt  in  1  block clock.
- master_rst_n  in  1  asynchronous active-low reset.
- master_serial_in  in  1  serial data from SDA.
- master_rec_data_shift  in  1  sample enable: one bit captured per cycle while high.
- master_rx_start  in  1  synchronous word restart: clears partial word and bit counter.
- master_rx_ready  in  1  consumer accepts head word.
- master_overrun_clr  in  1  clears the sticky overrun flag.
- master_data_out  out  DATA_W  FIFO head word; 0 when empty.
- master_rx_valid  out  1  FIFO non-empty.
- master_rx_count  out  $clog2(DEPTH+1)  FIFO occupancy.
- master_bit_cnt  out  $clog2(DATA_W)  bits captured in current word.
- master_byte_done  out  1  one-cycle pulse on the final bit of each word.
- master_rx_overrun  out  1  sticky: a completed word was dropped because the FIFO was full.

Behaviour:
- Interface: one clock, master_scl_sixt. Reset master_rst_n is asynchronous and active-low.
- Reset state: shift register, bit counter, FIFO pointers, count and overrun all 0. All outputs read 0; no byte_done pulse.
- Reset mid-word or mid-drain discards everything immediately.
- Shift, MSB_FIRST=1: sr <= {sr[DATA_W-2:0], serial_in}.
- Shift, MSB_FIRST=0: sr <= {serial_in, sr[DATA_W-1:1]}.
- Bit counter increments per sample. The counter and sr hold while shift is low; gaps of any length are allowed.
- Final sample (bit_cnt == DATA_W-1 and shift=1), all in the same edge:
  - the assembled word, including the current bit, is pushed;
  - byte_done is high for that cycle only (combinational from the qualifying sample);
  - bit_cnt wraps to 0.
- Push latency: the word is visible at master_data_out with valid=1 on the cycle after the final sample.
- rx_start: clears sr and bit_cnt. If shift is also high, the sampled bit becomes bit 0 of the new word (bit_cnt = 1). rx_start on the final-bit cycle cancels that push and suppresses byte_done.
- Pop: occurs when valid && ready. The head advances next edge. ready while empty is ignored.
- Push to a full FIFO with no pop: word dropped, overrun set, byte_done still pulses, contents unchanged.
- Full FIFO with simultaneous push and pop: both take effect, count stays DEPTH, no overrun.
- Empty FIFO with simultaneous push and pop: pop ignored, count becomes 1.
- Overrun: cleared by overrun_clr. If set and clear coincide, set wins. Overrun does not block later pushes once space exists.
- Pointers: log2(DEPTH) bits, wrap naturally. Count is a separate register: +1 on push, −1 on pop, unchanged on both or neither.

Decomposition:
- Package mast_i2c_pkg holds:
  - I2C_BYTE_W = 8;
  - MAST_RX_DEPTH_DEF = 4;
  - localparams BIT_ORDER_MSB = 1, BIT_ORDER_LSB = 0;
  - function clog2_safe for counter widths.
- One sub-module, mast_rx_fifo: DATA_W × DEPTH FWFT FIFO with push, pop, count and full/empty.
- Shift register, bit counter, start/byte_done logic and overrun flag stay in the top.

Test Plan:
1. Reset, MSB_FIRST=1, shift bits 1,0,1,0,0,1,0,1 on consecutive cycles -> byte_done high on the 8th sample cycle only; next cycle valid=1, data_out=0xA5, count=1.
2. Same 0xA5 with shift low for 1–3 random cycles between bits -> bit_cnt holds during gaps; single byte_done; data_out=0xA5.
3. MSB_FIRST=0 instance, serial 0,0,0,1,0,0,1,0 -> data_out=0x48. Same stimulus on an MSB_FIRST=1 instance -> 0x12.
4. DEPTH=4, ready=0, push 0x01..0x05 -> count=4, overrun=1 after the 5th byte_done. Then push 0x06 while ready=1 -> count stays 4, no new overrun. Drain returns 0x02,0x03,0x04,0x06. Overrun clears only after overrun_clr.
5. Three bits, then rx_start, then 0xC3 -> exactly one word, 0xC3, pushed. rx_start on the 8th bit -> no push, no byte_done.
6. Assert master_rst_n low asynchronously mid-word with count=2 -> all outputs 0 before the next clock edge. After release, a fresh 0x5A is received correctly.
